shift_reg_universal: RTL and testbench
======================================

// Module: shift_reg_universal
// PURPOSE
//  Parametrised universal shift register: the next generation of the 4-bit shift Registers block.
//  Per-cycle modes: hold, parallel load, logical shift, rotate and arithmetic shift right.
//  Adds a burst controller: one start request performs AMT back-to-back shifts, with busy/done handshake.
//  Used for barrel-less shifting of datapath values and for serial in/out of register contents.
// PARAMETERS
//  W    4   data width in bits (W >= 2)
//  AW   $clog2(W)+1   width of the burst shift count; derived, never overridden
// PORTS
//  CLK     in   1    clock; rising edge
//  RST     in   1    asynchronous, active-high reset
//  D       in   W    parallel load data
//  mode    in   3    operation select (encodings below)
//  en      in   1    apply mode this edge (single-step operation, idle only)
//  sin     in   1    serial input bit, shifted in by SHL/SHR
//  start   in   1    begin burst of amt shifts using mode (idle only)
//  amt     in   AW   burst shift count, 0..2^AW-1
//  Q       out  W    register contents
//  Q_next  out  W    combinational value Q will take at the next edge, given current inputs and state
//  sout    out  1    bit leaving the register: Q[W-1] for SHL/ROL; Q[0] for SHR/ROR/ASR; 0 otherwise
//  busy    out  1    burst in progress
//  done    out  1    one-cycle pulse after a burst completes
// BEHAVIOUR
//  Mode encoding: 0 HOLD, 1 LOAD (Q<=D), 2 SHL ({Q[W-2:0],sin}), 3 SHR ({sin,Q[W-1:1]}),
//   4 ROL ({Q[W-2:0],Q[W-1]}), 5 ROR ({Q[0],Q[W-1:1]}), 6 ASR ({Q[W-1],Q[W-1:1]}), 7 reserved = HOLD.
//  Reset (async, any time, mid-burst included): Q=0, busy=0, done=0, count=0, latched mode=HOLD.
//  Idle, start=0: if en=1, Q <= op(mode) at the edge; if en=0, Q holds. One-cycle latency.
//  Idle, start=1 (start has priority over en): no change to Q on the sampling edge.
//   If amt!=0 and mode is a shift mode (2..6): latch mode and amt; busy=1 from the next cycle.
//   Otherwise (amt=0 or mode is HOLD/LOAD/7): Q unchanged, busy stays 0, done=1 for the next cycle.
//  Busy: every edge applies op(latched mode), sampling sin live, and decrements count.
//   mode, en, D, start and amt are ignored while busy; start while busy is dropped, not queued.
//   On the edge where count goes 1->0: busy<=0 and done<=1.
//   done is high for exactly one cycle, the cycle after the last shift edge.
//  Latency: start sampled at edge k -> shifts at edges k+1..k+amt -> done high during cycle k+amt+1.
//   A new start may be sampled in the done cycle.
//  done is never high together with busy.
//  Q_next and sout use the latched mode while busy and the live mode/en/start while idle.
//   Idle with start=1: Q_next = Q.
//  Wrap-around: a ROL/ROR burst of amt=W returns the original Q.
//   SHL/SHR with amt>=W leaves Q fully refilled from sin.
//   An ASR burst of amt>=W leaves all bits equal to the original Q[W-1].
//  Count width AW is enough for amt up to 2W-1. No clamping: exactly amt shifts are performed.
// STRUCTURE
//  Package shift_pkg: mode localparams (MODE_HOLD..MODE_ASR) and the 3-bit mode type width.
//  Sub-module shift_op_unit (combinational, parameter W): inputs q, d, sin, mode; outputs nxt, sout.
//   Used for both Q_next and the register update, so the two cannot diverge.
//  Top level: Q register, burst FSM (IDLE/BUSY; done is a registered flag), AW-bit down-counter,
//   latched mode register.
// TESTING
//  1 Reset: assert RST mid-burst (W=4, Q=4'b1010, ROL amt=3, after 1 shift) -> Q=0, busy=0, done=0
//    immediately, before any clock edge.
//  2 Single step, W=4: LOAD D=4'b1001 en=1 -> Q=1001; SHL sin=1 -> 0011; SHR sin=0 -> 0001;
//    ASR from 1000 -> 1100; ROR from 0001 -> 1000; Q_next matches Q one edge earlier each time.
//  3 Burst: Q=4'b0110, ROL amt=5, start pulse -> busy high 5 cycles, Q=1100,1001,0011,0110,1100;
//    done high one cycle after; sout shows 0,1,1,0,0 on successive busy cycles.
//  4 Degenerate: start with amt=0, and start with mode=LOAD amt=3 -> Q unchanged, busy never high,
//    done pulses the next cycle.
//  5 Conflicts: start and en both high while idle -> burst taken, en ignored; start/en/mode toggled
//    while busy -> ignored; new start in the done cycle -> accepted, busy next cycle.
//  6 Serial fill: W=8, SHR amt=8, sin driven with 8'hA5 LSB-first -> Q=8'hA5 at done.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared mode encodings and FSM state type for the universal shift register.
package shift_pkg;

  localparam int unsigned ModeW = 3;
  typedef logic [ModeW-1:0] mode_t;

  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_LOAD = 3'd1;
  localparam mode_t MODE_SHL  = 3'd2;
  localparam mode_t MODE_SHR  = 3'd3;
  localparam mode_t MODE_ROL  = 3'd4;
  localparam mode_t MODE_ROR  = 3'd5;
  localparam mode_t MODE_ASR  = 3'd6;

  typedef enum logic [0:0] {StIdle, StBusy} burst_state_e;

  function automatic logic is_shift_mode(mode_t m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_op_unit.sv
// Combinational single-step operation: next register value and the bit shifted out.
module shift_op_unit
  import shift_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  input  logic         sin,
  input  mode_t        mode,
  output logic [W-1:0] nxt,
  output logic         sout
);

  always_comb begin
    nxt  = q;
    sout = 1'b0;
    case (mode)
      MODE_LOAD: nxt = d;
      MODE_SHL: begin
        nxt  = {q[W-2:0], sin};
        sout = q[W-1];
      end
      MODE_SHR: begin
        nxt  = {sin, q[W-1:1]};
        sout = q[0];
      end
      MODE_ROL: begin
        nxt  = {q[W-2:0], q[W-1]};
        sout = q[W-1];
      end
      MODE_ROR: begin
        nxt  = {q[0], q[W-1:1]};
        sout = q[0];
      end
      MODE_ASR: begin
        nxt  = {q[W-1], q[W-1:1]};
        sout = q[0];
      end
      default: nxt = q;
    endcase
  end

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register with single-step modes and a burst controller (busy/done handshake).
module shift_reg_universal
  import shift_pkg::*;
#(
  parameter int unsigned W = 4,
  localparam int unsigned AW = $clog2(W) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [W-1:0]  D,
  input  logic [2:0]    mode,
  input  logic          en,
  input  logic          sin,
  input  logic          start,
  input  logic [AW-1:0] amt,
  output logic [W-1:0]  Q,
  output logic [W-1:0]  Q_next,
  output logic          sout,
  output logic          busy,
  output logic          done
);

  burst_state_e  state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [AW-1:0] cnt_q, cnt_d;
  mode_t         mode_q, mode_d;
  logic          done_q, done_d;

  mode_t         op_mode;
  logic [W-1:0]  op_nxt;
  logic          op_sout;

  assign op_mode = (state_q == StBusy) ? mode_q : mode;

  shift_op_unit #(
    .W (W)
  ) u_op (
    .q    (q_q),
    .d    (D),
    .sin  (sin),
    .mode (op_mode),
    .nxt  (op_nxt),
    .sout (op_sout)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    sout    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Start wins over en; degenerate bursts only produce a done pulse.
          if ((amt != '0) && is_shift_mode(mode)) begin
            state_d = StBusy;
            mode_d  = mode;
            cnt_d   = amt;
          end else begin
            done_d = 1'b1;
          end
        end else if (en) begin
          q_d  = op_nxt;
          sout = op_sout;
        end
      end
      StBusy: begin
        q_d   = op_nxt;
        sout  = op_sout;
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = StIdle;
          mode_d  = MODE_HOLD;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      q_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign Q      = q_q;
  assign Q_next = q_d;
  assign busy   = (state_q == StBusy);
  assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed self-checking bench for shift_reg_universal (W=4 and W=8 instances).
module tb_shift_reg_universal;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;

  logic [3:0] D = '0;
  logic [2:0] mode = '0;
  logic       en = 1'b0, sin = 1'b0, start = 1'b0;
  logic [2:0] amt = '0;
  logic [3:0] Q, Q_next;
  logic       sout, busy, done;

  logic [7:0] D8 = '0;
  logic [2:0] mode8 = '0;
  logic       en8 = 1'b0, sin8 = 1'b0, start8 = 1'b0;
  logic [3:0] amt8 = '0;
  logic [7:0] Q8, Q_next8;
  logic       sout8, busy8, done8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  shift_reg_universal #(.W(4)) dut (
    .CLK (CLK), .RST (RST), .D (D), .mode (mode), .en (en), .sin (sin),
    .start (start), .amt (amt), .Q (Q), .Q_next (Q_next), .sout (sout),
    .busy (busy), .done (done)
  );

  shift_reg_universal #(.W(8)) dut8 (
    .CLK (CLK), .RST (RST), .D (D8), .mode (mode8), .en (en8), .sin (sin8),
    .start (start8), .amt (amt8), .Q (Q8), .Q_next (Q_next8), .sout (sout8),
    .busy (busy8), .done (done8)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Single-step op: checks Q_next before the edge and Q after it.
  task automatic single(input logic [2:0] m, input logic [3:0] d, input logic s,
                        input logic [3:0] exp, input string tag);
    mode = m; D = d; sin = s; en = 1'b1;
    #1;
    chk({tag, "_qnext"}, {4'h0, Q_next}, {4'h0, exp});
    step();
    chk({tag, "_q"}, {4'h0, Q}, {4'h0, exp});
    en = 1'b0;
  endtask

  logic [3:0] exp_q   [5] = '{4'b1100, 4'b1001, 4'b0011, 4'b0110, 4'b1100};
  logic       exp_so  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] pat;

  initial begin
    #2;
    chk("rst_q", {4'h0, Q}, 8'h00);
    chk("rst_busy", {7'h0, busy}, 8'h00);
    chk("rst_done", {7'h0, done}, 8'h00);
    #10 RST = 1'b0;
    step();

    // Single-step modes
    single(3'd1, 4'b1001, 1'b0, 4'b1001, "load");
    single(3'd2, 4'b0000, 1'b1, 4'b0011, "shl");
    single(3'd3, 4'b0000, 1'b0, 4'b0001, "shr");
    single(3'd1, 4'b1000, 1'b0, 4'b1000, "load2");
    single(3'd6, 4'b0000, 1'b0, 4'b1100, "asr");
    single(3'd1, 4'b0001, 1'b0, 4'b0001, "load3");
    single(3'd5, 4'b0000, 1'b0, 4'b1000, "ror");
    single(3'd7, 4'b1111, 1'b1, 4'b1000, "rsvd_hold");

    // Async reset mid-burst
    single(3'd1, 4'b1010, 1'b0, 4'b1010, "load_rst");
    mode = 3'd4; amt = 3'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("rst_pre_busy", {7'h0, busy}, 8'h01);
    step();
    chk("rst_pre_q", {4'h0, Q}, 8'h05);
    #2 RST = 1'b1;
    #1;
    chk("arst_q", {4'h0, Q}, 8'h00);
    chk("arst_busy", {7'h0, busy}, 8'h00);
    chk("arst_done", {7'h0, done}, 8'h00);
    #1 RST = 1'b0;
    step();
    chk("arst_stay_idle", {7'h0, busy}, 8'h00);

    // ROL burst of 5
    single(3'd1, 4'b0110, 1'b0, 4'b0110, "load_b");
    mode = 3'd4; amt = 3'd5; start = 1'b1;
    #1;
    chk("start_qnext", {4'h0, Q_next}, 8'h06);
    step();
    start = 1'b0;
    chk("b_q_start", {4'h0, Q}, 8'h06);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("b_busy%0d", i), {7'h0, busy}, 8'h01);
      chk($sformatf("b_done%0d", i), {7'h0, done}, 8'h00);
      chk($sformatf("b_sout%0d", i), {7'h0, sout}, {7'h0, exp_so[i]});
      step();
      chk($sformatf("b_q%0d", i), {4'h0, Q}, {4'h0, exp_q[i]});
    end
    chk("b_end_busy", {7'h0, busy}, 8'h00);
    chk("b_end_done", {7'h0, done}, 8'h01);
    step();
    chk("b_done_drop", {7'h0, done}, 8'h00);

    // Degenerate starts
    mode = 3'd2; amt = 3'd0; start = 1'b1; sin = 1'b1;
    step();
    start = 1'b0;
    chk("amt0_q", {4'h0, Q}, 8'h0C);
    chk("amt0_busy", {7'h0, busy}, 8'h00);
    chk("amt0_done", {7'h0, done}, 8'h01);
    step();
    chk("amt0_done_drop", {7'h0, done}, 8'h00);
    mode = 3'd1; amt = 3'd3; D = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    chk("ldst_q", {4'h0, Q}, 8'h0C);
    chk("ldst_busy", {7'h0, busy}, 8'h00);
    chk("ldst_done", {7'h0, done}, 8'h01);
    step();
    chk("ldst_done_drop", {7'h0, done}, 8'h00);

    // Conflicts: start+en, inputs toggled while busy, restart in done cycle
    mode = 3'd3; amt = 3'd2; start = 1'b1; en = 1'b1; sin = 1'b0;
    step();
    chk("cf_q_start", {4'h0, Q}, 8'h0C);
    chk("cf_busy", {7'h0, busy}, 8'h01);
    mode = 3'd1; D = 4'b0000; amt = 3'd7; start = 1'b1; en = 1'b1; sin = 1'b1;
    step();
    chk("cf_q1", {4'h0, Q}, 8'h0E);
    en = 1'b0; start = 1'b0;
    step();
    chk("cf_q2", {4'h0, Q}, 8'h0F);
    chk("cf_busy_end", {7'h0, busy}, 8'h00);
    chk("cf_done", {7'h0, done}, 8'h01);
    mode = 3'd2; amt = 3'd1; start = 1'b1; sin = 1'b0;
    step();
    start = 1'b0;
    chk("re_busy", {7'h0, busy}, 8'h01);
    chk("re_done", {7'h0, done}, 8'h00);
    step();
    chk("re_q", {4'h0, Q}, 8'h0E);
    chk("re_done2", {7'h0, done}, 8'h01);

    // W=8 serial fill, SHR amt=8, A5 LSB-first
    pat = 8'hA5;
    mode8 = 3'd3; amt8 = 4'd8; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sin8 = pat[i];
      step();
    end
    chk("fill_q", Q8, 8'hA5);
    chk("fill_done", {7'h0, done8}, 8'h01);
    chk("fill_busy", {7'h0, busy8}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
